shoe_dealer: RTL and testbench

Multi-deck card shoe for the Blackjack game. Holds NUM_DECKS×52 cards in an internal RAM and shuffles them in place with a Fisher-Yates pass driven by a free-running LFSR. Deals cards without replacement through a request/valid handshake. Flags when the cut-card depth is reached so the game FSM can schedule a reshuffle. Sits between the game controller and the hand/score logic.

---
 rtl/shoe_dealer.sv | 189 ++++++++++++++++++
 tb/tb_shoe_dealer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shoe_dealer.sv
// Multi-deck Blackjack shoe: RAM-backed deck, LFSR-driven Fisher-Yates shuffle, request/valid dealing.
// Optional `SHOE_SEED_EN adds a seed input that reloads the LFSR on every entry to INIT.
module shoe_dealer #(
  parameter int NUM_DECKS  = 6,
  parameter int LFSR_W     = 16,
  parameter int CUT_REMAIN = 78,
  localparam int TOTAL     = NUM_DECKS * 52,
  localparam int CNT_W     = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SHOE_SEED_EN
  input  logic [LFSR_W-1:0] seed,
`endif
  input  logic             shuffle_req,
  input  logic             draw_req,
  output logic             busy,
  output logic             card_valid,
  output logic [3:0]       card_rank,
  output logic [3:0]       card_points,
  output logic [CNT_W-1:0] cards_left,
  output logic             cut_reached,
  output logic             empty
);

  typedef enum logic [2:0] {
    S_INIT, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_READY, S_FETCH, S_DEAL
  } state_t;

  localparam logic [31:0] TAPS32 = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                   (LFSR_W == 12) ? 32'h0000_0E08 :
                                   (LFSR_W == 24) ? 32'h00E1_0000 :
                                   (LFSR_W == 32) ? 32'hA300_0000 : 32'h0000_B400;
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(TAPS32);
  localparam logic [LFSR_W-1:0] SEED_DEF = LFSR_W'(32'h0000_ACE1);

  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? TAPS : '0);
  endfunction

  state_t            state_q;
  logic [CNT_W-1:0]  idx_q, j_q, ptr_q, left_q;
  logic [3:0]        init_rank_q, tmp_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              shuf_pend_q;
  logic              card_valid_q;
  logic [3:0]        card_rank_q, card_points_q;
`ifdef SHOE_SEED_EN
  logic              seed_pend_q;
  logic [LFSR_W-1:0] seed_val;
  assign seed_val = (seed != '0) ? seed : SEED_DEF;
`endif

  logic [3:0]        mem [0:TOTAL-1];
  logic [3:0]        rdata_q;
  logic [CNT_W-1:0]  mem_addr;
  logic              mem_we;
  logic [3:0]        mem_wdata;

  // Swap partner j = floor(lfsr * (i+1) / 2^LFSR_W), always in 0..i
  logic [LFSR_W+CNT_W-1:0] prod;
  logic [CNT_W-1:0]        j_d;
  assign prod = (LFSR_W+CNT_W)'(lfsr_q) * (LFSR_W+CNT_W)'(idx_q + CNT_W'(1));
  assign j_d  = CNT_W'(prod >> LFSR_W);

  always_comb begin
    mem_addr  = ptr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_INIT: begin mem_addr = idx_q; mem_we = 1'b1; mem_wdata = init_rank_q; end
      S_RD_I: mem_addr = idx_q;
      S_RD_J: mem_addr = j_q;
      S_WR_I: begin mem_addr = idx_q; mem_we = 1'b1; mem_wdata = rdata_q; end
      S_WR_J: begin mem_addr = j_q;   mem_we = 1'b1; mem_wdata = tmp_q;   end
      default: mem_addr = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rdata_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT;
      idx_q         <= '0;
      j_q           <= '0;
      ptr_q         <= '0;
      left_q        <= '0;
      init_rank_q   <= 4'd1;
      tmp_q         <= '0;
      lfsr_q        <= SEED_DEF;
      shuf_pend_q   <= 1'b0;
      card_valid_q  <= 1'b0;
      card_rank_q   <= '0;
      card_points_q <= '0;
`ifdef SHOE_SEED_EN
      seed_pend_q   <= 1'b1;
`endif
    end else begin
      lfsr_q       <= lfsr_adv(lfsr_q);
      card_valid_q <= 1'b0;
      case (state_q)
        S_INIT: begin
`ifdef SHOE_SEED_EN
          if (seed_pend_q) begin
            lfsr_q      <= lfsr_adv(seed_val);
            seed_pend_q <= 1'b0;
          end
`endif
          init_rank_q <= (init_rank_q == 4'd13) ? 4'd1 : init_rank_q + 4'd1;
          if (idx_q == CNT_W'(TOTAL - 1)) state_q <= S_RD_I;
          else idx_q <= idx_q + CNT_W'(1);
        end
        S_RD_I: begin
          j_q     <= j_d;
          state_q <= S_RD_J;
        end
        S_RD_J: begin
          tmp_q   <= rdata_q;
          state_q <= S_WR_I;
        end
        S_WR_I: state_q <= S_WR_J;
        S_WR_J: begin
          if (idx_q == CNT_W'(1)) begin
            state_q <= S_READY;
            left_q  <= CNT_W'(TOTAL);
            ptr_q   <= '0;
          end else begin
            idx_q   <= idx_q - CNT_W'(1);
            state_q <= S_RD_I;
          end
        end
        S_READY: begin
          if (shuffle_req) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            init_rank_q <= 4'd1;
            left_q      <= '0;
            ptr_q       <= '0;
`ifdef SHOE_SEED_EN
            lfsr_q      <= seed_val;
`endif
          end else if (draw_req && left_q != '0) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          shuf_pend_q   <= shuf_pend_q | shuffle_req;
          card_valid_q  <= 1'b1;
          card_rank_q   <= rdata_q;
          card_points_q <= (rdata_q > 4'd10) ? 4'd10 : rdata_q;
          state_q       <= S_DEAL;
        end
        S_DEAL: begin
          // Pointer saturates on the final card so it never leaves the RAM range
          if (left_q != CNT_W'(1)) ptr_q <= ptr_q + CNT_W'(1);
          left_q <= left_q - CNT_W'(1);
          if (shuf_pend_q || shuffle_req) begin
            shuf_pend_q <= 1'b0;
            state_q     <= S_INIT;
            idx_q       <= '0;
            init_rank_q <= 4'd1;
            left_q      <= '0;
            ptr_q       <= '0;
`ifdef SHOE_SEED_EN
            lfsr_q      <= seed_val;
`endif
          end else begin
            state_q <= S_READY;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign busy        = (state_q == S_INIT) || (state_q == S_RD_I) || (state_q == S_RD_J) ||
                       (state_q == S_WR_I) || (state_q == S_WR_J);
  assign card_valid  = card_valid_q;
  assign card_rank   = card_rank_q;
  assign card_points = card_points_q;
  assign cards_left  = left_q;
  assign empty       = (left_q == '0);
  assign cut_reached = (left_q <= CNT_W'(CUT_REMAIN));

endmodule

// File: tb/tb_shoe_dealer.sv
// Directed bench for shoe_dealer: a 1-deck and a 6-deck instance share one clock.
// Expected post-deal card counts go through a scoreboard queue and are popped when a card appears.
module tb_shoe_dealer;
  logic       clk;
  logic       rst   [2];
  logic       sreq  [2];
  logic       dreq  [2];
  logic       busy_w[2];
  logic       cv    [2];
  logic       cut_w [2];
  logic       emp_w [2];
  logic [3:0] rank_w[2];
  logic [3:0] pts_w [2];
  logic [5:0] cl1;
  logic [8:0] cl6;
  logic [8:0] cl    [2];
  assign cl[0] = {3'b000, cl1};
  assign cl[1] = cl6;
`ifdef SHOE_SEED_EN
  logic [15:0] seed_r = 16'h0000;
`endif

  shoe_dealer #(.NUM_DECKS(1), .LFSR_W(16), .CUT_REMAIN(13)) u_d1 (
    .clk(clk), .reset(rst[0]),
`ifdef SHOE_SEED_EN
    .seed(seed_r),
`endif
    .shuffle_req(sreq[0]), .draw_req(dreq[0]), .busy(busy_w[0]), .card_valid(cv[0]),
    .card_rank(rank_w[0]), .card_points(pts_w[0]), .cards_left(cl1),
    .cut_reached(cut_w[0]), .empty(emp_w[0])
  );

  shoe_dealer #(.NUM_DECKS(6), .LFSR_W(16), .CUT_REMAIN(78)) u_d6 (
    .clk(clk), .reset(rst[1]),
`ifdef SHOE_SEED_EN
    .seed(seed_r),
`endif
    .shuffle_req(sreq[1]), .draw_req(dreq[1]), .busy(busy_w[1]), .card_valid(cv[1]),
    .card_rank(rank_w[1]), .card_points(pts_w[1]), .cards_left(cl6),
    .cut_reached(cut_w[1]), .empty(emp_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_left  [2];
  int exp_valid [2];
  int vcount    [2];
  int cut_p     [2];
  int deck_sz   [2];
  int tally     [14];
  int sb_q [$];

  always @(negedge clk) begin
    if (cv[0] === 1'b1) vcount[0]++;
    if (cv[1] === 1'b1) vcount[1]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pmap(input int r);
    return (r > 10) ? 10 : r;
  endfunction

  task automatic chk_reset(input int i);
    chk("rst_busy",  32'(busy_w[i]), 1);
    chk("rst_empty", 32'(emp_w[i]),  1);
    chk("rst_cut",   32'(cut_w[i]),  1);
    chk("rst_valid", 32'(cv[i]),     0);
    chk("rst_rank",  32'(rank_w[i]), 0);
    chk("rst_pts",   32'(pts_w[i]),  0);
    chk("rst_left",  32'(cl[i]),     0);
  endtask

  // Count busy cycles starting with the current one, then expect a full shoe
  task automatic wait_idle(input int i, input int exp_n);
    int n = 0;
    for (int c = 0; c < 4000 && busy_w[i] === 1'b1; c++) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, exp_n);
    exp_left[i] = deck_sz[i];
    chk("full_left",  32'(cl[i]),    exp_left[i]);
    chk("full_cut",   32'(cut_w[i]), 0);
    chk("full_empty", 32'(emp_w[i]), 0);
  endtask

  // mode 0: plain draw; 1: extra draw_req during FETCH; 2: shuffle_req during FETCH
  task automatic draw(input int i, input int mode);
    bit exp_card;
    int e;
    int r;
    exp_card = (exp_left[i] != 0);
    dreq[i] = 1'b1;
    if (exp_card) begin
      sb_q.push_back((mode == 2) ? 0 : exp_left[i] - 1);
      exp_valid[i]++;
    end
    tick();
    dreq[i] = 1'b0;
    if (mode == 1) dreq[i] = 1'b1;
    if (mode == 2) sreq[i] = 1'b1;
    chk("fetch_no_valid", 32'(cv[i]), 0);
    tick();
    dreq[i] = 1'b0;
    sreq[i] = 1'b0;
    e = exp_left[i];
    if (exp_card) begin
      r = int'(rank_w[i]);
      chk("deal_valid", 32'(cv[i]), 1);
      chk("rank_range", 32'(r >= 1 && r <= 13), 1);
      chk("points_map", 32'(pts_w[i]), pmap(r));
      if (r >= 1 && r <= 13) tally[r]++;
      e = sb_q.pop_front();
    end else begin
      chk("no_deal", 32'(cv[i]), 0);
    end
    tick();
    if (mode == 2) begin
      chk("shuf_busy", 32'(busy_w[i]), 1);
      chk("shuf_left", 32'(cl[i]), e);
      exp_left[i] = 0;
    end else begin
      if (exp_card) exp_left[i]--;
      chk("left",       32'(cl[i]),    e);
      chk("empty",      32'(emp_w[i]), (exp_left[i] == 0) ? 1 : 0);
      chk("cut",        32'(cut_w[i]), (exp_left[i] <= cut_p[i]) ? 1 : 0);
      chk("post_valid", 32'(cv[i]),    0);
    end
    if (mode == 1) begin
      tick();
      chk("redraw_no_valid", 32'(cv[i]), 0);
      chk("redraw_left",     32'(cl[i]), exp_left[i]);
    end
  endtask

  task automatic deck_check(input int i);
    for (int r = 0; r < 14; r++) tally[r] = 0;
    draw(i, 1);
    for (int k = 1; k < 52; k++) draw(i, 0);
    for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), tally[r], 4);
  endtask

  initial begin
    cut_p   = '{13, 78};
    deck_sz = '{52, 312};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; sreq[i] = 1'b0; dreq[i] = 1'b0;
      exp_left[i] = 0; exp_valid[i] = 0; vcount[i] = 0;
    end
    tick();
    tick();
    chk_reset(0);
    chk_reset(1);

    // Initial build+shuffle of both shoes, counted side by side
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    begin
      int n0 = 0;
      int n1 = 0;
      for (int c = 0; c < 4000; c++) begin
        if (busy_w[0] === 1'b1) n0++;
        if (busy_w[1] === 1'b1) n1++;
        if (busy_w[0] !== 1'b1 && busy_w[1] !== 1'b1) break;
        tick();
      end
      chk("init_busy_d1", n0, 256);
      chk("init_busy_d6", n1, 1556);
      exp_left[0] = 52;
      exp_left[1] = 312;
      chk("ready_left_d1", 32'(cl[0]), 52);
      chk("ready_left_d6", 32'(cl[1]), 312);
    end

    // One deck dealt out completely, then a draw on the empty shoe
    deck_check(0);
    chk("deck_empty", 32'(emp_w[0]), 1);
    draw(0, 0);

    // Six decks: cut-card crossing at 78 left, then reshuffle
    for (int k = 1; k <= 240; k++) draw(1, 0);
    sreq[1] = 1'b1;
    tick();
    sreq[1] = 1'b0;
    chk("d6_shuf_left", 32'(cl[1]), 0);
    wait_idle(1, 1556);

    // Refill, then shuffle_req colliding with draw_req, then shuffle_req during FETCH
    sreq[0] = 1'b1;
    tick();
    sreq[0] = 1'b0;
    wait_idle(0, 256);
    sreq[0] = 1'b1;
    dreq[0] = 1'b1;
    tick();
    sreq[0] = 1'b0;
    dreq[0] = 1'b0;
    chk("collide_no_valid", 32'(cv[0]), 0);
    chk("collide_busy",     32'(busy_w[0]), 1);
    chk("collide_left",     32'(cl[0]), 0);
    exp_left[0] = 0;
    wait_idle(0, 256);
    draw(0, 2);
    wait_idle(0, 256);

    // Reset in the middle of SHUFFLE
    sreq[0] = 1'b1;
    tick();
    sreq[0] = 1'b0;
    repeat (100) tick();
    chk("pre_reset_busy", 32'(busy_w[0]), 1);
    rst[0] = 1'b1;
    #1;
    chk_reset(0);
    tick();
    rst[0] = 1'b0;
    wait_idle(0, 256);

    // Reset while a deal is in flight
    dreq[0] = 1'b1;
    tick();
    dreq[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    chk_reset(0);
    tick();
    chk("abort_no_valid", 32'(cv[0]), 0);
    tick();
    rst[0] = 1'b0;
    wait_idle(0, 256);
    deck_check(0);

    repeat (3) tick();
    chk("valid_pulses_d1", vcount[0], exp_valid[0]);
    chk("valid_pulses_d6", vcount[1], exp_valid[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
